blob_track_ctrl: RTL and testbench

- Frame-level sequencer behind the HSV colour classifier: consumes the per-pixel 3-bit class stream with pixel coordinates and accumulates the count, x-sum and y-sum of pixels matching a selected target class.
- At frame end it runs a shared sequential divider to produce the blob centroid, then presents it on a valid/ready handshake to the steering logic.
- Runs once per camera frame.

---
 rtl/chase_pkg.sv | 24 ++
 rtl/seq_divider.sv | 71 +++++++
 rtl/blob_track_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_blob_track_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
// Shared types for the blob tracker: classifier codes, controller states and
// the default camera frame geometry the widths are derived from.
package chase_pkg;

    typedef enum logic [2:0] {
        CLS_RED    = 3'b001,
        CLS_ORANGE = 3'b100,
        CLS_YELLOW = 3'b010,
        CLS_WARM   = 3'b011,
        CLS_NONE   = 3'b111
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DIV_X,
        ST_DIV_Y,
        ST_OUT
    } state_e;

    localparam int FRAME_W = 320;
    localparam int FRAME_H = 240;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. The start cycle
// already retires the first bit, so done pulses exactly W cycles after start.
module seq_divider #(
    parameter int W     = 26,
    parameter int CNT_W = 17
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [W-1:0]     dividend_in,
    input  logic [CNT_W-1:0] divisor_in,
    output logic [W-1:0]     quotient_out,
    output logic             done_out
);

    localparam int CW = $clog2(W + 1);

    logic [CNT_W-1:0] rem_q, rem_d, dsr_q, dsr_d, rem_src, dsr_src, diff;
    logic [W-1:0]     quo_q, quo_d, quo_src;
    logic [CNT_W:0]   trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        rem_src = start_in ? '0 : rem_q;
        quo_src = start_in ? dividend_in : quo_q;
        dsr_src = start_in ? divisor_in : dsr_q;
        trial   = {rem_src, quo_src[W-1]};
        // Remainder stays below the divisor, so the low CNT_W bits are exact.
        diff    = trial[CNT_W-1:0] - dsr_src;

        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (start_in || (cnt_q != '0)) begin
            dsr_d = dsr_src;
            if (trial >= {1'b0, dsr_src}) begin
                rem_d = diff;
                quo_d = {quo_src[W-2:0], 1'b1};
            end else begin
                rem_d = trial[CNT_W-1:0];
                quo_d = {quo_src[W-2:0], 1'b0};
            end
            cnt_d  = start_in ? CW'(W - 1) : cnt_q - CW'(1);
            done_d = !start_in && (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk_in) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dsr_q <= dsr_d;
    end

    assign quotient_out = quo_q;
    assign done_out     = done_q;

endmodule

// File: rtl/blob_track_ctrl.sv
// Per-frame blob tracker: accumulates count and coordinate sums of pixels of
// the target class, divides for the centroid and offers it on valid/ready.
module blob_track_ctrl
    import chase_pkg::*;
#(
    parameter int H_W     = $clog2(FRAME_W),
    parameter int V_W     = $clog2(FRAME_H),
    parameter int CNT_W   = $clog2(FRAME_W * FRAME_H + 1),
    parameter int SUM_W   = 26,
    parameter int MIN_PIX = 64
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             frame_start_in,
    input  logic             frame_end_in,
    input  logic             pix_valid_in,
    input  logic [2:0]       cls_in,
    input  logic [H_W-1:0]   x_in,
    input  logic [V_W-1:0]   y_in,
    input  logic [2:0]       target_cls_in,
    output logic [H_W-1:0]   cx_out,
    output logic [V_W-1:0]   cy_out,
    output logic [CNT_W-1:0] pix_count_out,
    output logic             found_out,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic             busy_out,
    output logic [7:0]       drop_count_out
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, pix_count_q, pix_count_d;
    logic [SUM_W-1:0] xsum_q, xsum_d, ysum_q, ysum_d;
    logic [2:0]       target_q, target_d;
    logic [H_W-1:0]   cx_q, cx_d;
    logic [V_W-1:0]   cy_q, cy_d;
    logic             found_q, found_d;
    logic [7:0]       drop_q, drop_d;
    logic             match;
    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_quo;
    logic [CNT_W-1:0] div_divisor;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

    // Saturated sums can push the quotient past the frame; clamp instead of wrapping.
    function automatic logic [H_W-1:0] clamp_x(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:H_W]) ? {H_W{1'b1}} : q[H_W-1:0];
    endfunction

    function automatic logic [V_W-1:0] clamp_y(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:V_W]) ? {V_W{1'b1}} : q[V_W-1:0];
    endfunction

    assign match = pix_valid_in && (cls_in == target_q) && (target_q != CLS_NONE);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        xsum_d       = xsum_q;
        ysum_d       = ysum_q;
        target_d     = target_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        pix_count_d  = pix_count_q;
        found_d      = found_q;
        drop_d       = drop_q;
        div_start    = 1'b0;
        div_dividend = ysum_q;
        div_divisor  = count_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start_in) begin
                    state_d  = ST_ACCUM;
                    count_d  = '0;
                    xsum_d   = '0;
                    ysum_d   = '0;
                    target_d = target_cls_in;
                end
            end
            ST_ACCUM: begin
                if (frame_start_in) begin
                    count_d  = '0;
                    xsum_d   = '0;
                    ysum_d   = '0;
                    target_d = target_cls_in;
                end else begin
                    if (match) begin
                        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        xsum_d  = sat_add(xsum_q, SUM_W'(x_in));
                        ysum_d  = sat_add(ysum_q, SUM_W'(y_in));
                    end
                    // Uses the _d values so a pixel on the frame_end cycle counts.
                    if (frame_end_in) begin
                        pix_count_d = count_d;
                        found_d     = (count_d >= MIN_CNT);
                        if (count_d >= MIN_CNT) begin
                            state_d      = ST_DIV_X;
                            div_start    = 1'b1;
                            div_dividend = xsum_d;
                            div_divisor  = count_d;
                        end else begin
                            state_d = ST_OUT;
                            cx_d    = '0;
                            cy_d    = '0;
                        end
                    end
                end
            end
            ST_DIV_X: begin
                if (div_done) begin
                    cx_d      = clamp_x(div_quo);
                    div_start = 1'b1;
                    state_d   = ST_DIV_Y;
                end
            end
            ST_DIV_Y: begin
                if (div_done) begin
                    cy_d    = clamp_y(div_quo);
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_ready_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_start_in && (state_q inside {ST_DIV_X, ST_DIV_Y, ST_OUT})) begin
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            xsum_q      <= '0;
            ysum_q      <= '0;
            target_q    <= CLS_NONE;
            cx_q        <= '0;
            cy_q        <= '0;
            pix_count_q <= '0;
            found_q     <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            xsum_q      <= xsum_d;
            ysum_q      <= ysum_d;
            target_q    <= target_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            pix_count_q <= pix_count_d;
            found_q     <= found_d;
            drop_q      <= drop_d;
        end
    end

    seq_divider #(
        .W     (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .start_in     (div_start),
        .dividend_in  (div_dividend),
        .divisor_in   (div_divisor),
        .quotient_out (div_quo),
        .done_out     (div_done)
    );

    assign cx_out         = cx_q;
    assign cy_out         = cy_q;
    assign pix_count_out  = pix_count_q;
    assign found_out      = found_q;
    assign res_valid_out  = (state_q == ST_OUT);
    assign busy_out       = (state_q != ST_IDLE);
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_blob_track_ctrl.sv
// Directed bench for blob_track_ctrl: a frame-level reference model is compared
// every cycle, plus hand-computed centroid, latency and drop expectations.
module tb_blob_track_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        frame_end_in = 1'b0;
    logic        pix_valid_in = 1'b0;
    logic [2:0]  cls_in = 3'b111;
    logic [8:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [2:0]  target_cls_in = 3'b001;
    logic        res_ready_in = 1'b1;
    logic [8:0]  cx_out;
    logic [7:0]  cy_out;
    logic [16:0] pix_count_out;
    logic        found_out;
    logic        res_valid_out;
    logic        busy_out;
    logic [7:0]  drop_count_out;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: 0 idle, 1 accumulating, 2 computing, 3 presenting.
    int m_phase = 0, m_cnt = 0, m_xs = 0, m_ys = 0, m_tgt = 0, m_wait = 0, m_drop = 0;
    int e_cx = 0, e_cy = 0, e_cnt = 0, e_found = 0;

    blob_track_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .frame_start_in (frame_start_in),
        .frame_end_in   (frame_end_in),
        .pix_valid_in   (pix_valid_in),
        .cls_in         (cls_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .target_cls_in  (target_cls_in),
        .cx_out         (cx_out),
        .cy_out         (cy_out),
        .pix_count_out  (pix_count_out),
        .found_out      (found_out),
        .res_valid_out  (res_valid_out),
        .res_ready_in   (res_ready_in),
        .busy_out       (busy_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    always @(posedge clk_in) begin : model
        int c, xs, ys;
        c = m_cnt;
        xs = m_xs;
        ys = m_ys;
        if (!rst_n_in) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_xs    <= 0;
            m_ys    <= 0;
            m_drop  <= 0;
        end else begin
            if (frame_start_in && m_phase >= 2 && m_drop < 255) m_drop <= m_drop + 1;
            case (m_phase)
                0, 1: begin
                    if (frame_start_in) begin
                        m_phase <= 1;
                        m_cnt <= 0;
                        m_xs <= 0;
                        m_ys <= 0;
                        m_tgt <= int'(target_cls_in);
                    end else if (m_phase == 1) begin
                        if (pix_valid_in && int'(cls_in) == m_tgt && m_tgt != 7) begin
                            c = c + 1;
                            xs = xs + int'(x_in);
                            ys = ys + int'(y_in);
                        end
                        m_cnt <= c;
                        m_xs <= xs;
                        m_ys <= ys;
                        if (frame_end_in) begin
                            e_cnt <= c;
                            if (c >= 64) begin
                                e_found <= 1;
                                e_cx <= xs / c;
                                e_cy <= ys / c;
                                m_wait <= 52;
                                m_phase <= 2;
                            end else begin
                                e_found <= 0;
                                e_cx <= 0;
                                e_cy <= 0;
                                m_phase <= 3;
                            end
                        end
                    end
                end
                2: begin
                    if (m_wait == 1) m_phase <= 3;
                    m_wait <= m_wait - 1;
                end
                default: begin
                    if (res_ready_in) m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("busy", busy_out, (m_phase != 0));
            check("res_valid", res_valid_out, (m_phase == 3));
            check("drop_count", drop_count_out, m_drop);
            if (m_phase == 3) begin
                check("cx", cx_out, e_cx);
                check("cy", cy_out, e_cy);
                check("pix_count", pix_count_out, e_cnt);
                check("found", found_out, e_found);
            end
        end
    end

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic start_frame(input logic [2:0] t);
        target_cls_in = t;
        frame_start_in = 1'b1;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    task automatic pixel(input logic [2:0] c, input int x, input int y);
        pix_valid_in = 1'b1;
        cls_in = c;
        x_in = x[8:0];
        y_in = y[7:0];
        @(negedge clk_in);
        pix_valid_in = 1'b0;
    endtask

    task automatic end_frame(input bit with_pix, input logic [2:0] c, input int x, input int y);
        frame_end_in = 1'b1;
        pix_valid_in = with_pix;
        cls_in = c;
        x_in = x[8:0];
        y_in = y[7:0];
        @(negedge clk_in);
        frame_end_in = 1'b0;
        pix_valid_in = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int exp_lat);
        int lat = 1;
        while (!res_valid_out && lat < 300) begin
            @(negedge clk_in);
            lat++;
        end
        check(nm, lat, exp_lat);
    endtask

    task automatic check_result(input string nm, input int cx, input int cy,
                                input int cnt, input int fnd);
        check({nm, "_cx"}, cx_out, cx);
        check({nm, "_cy"}, cy_out, cy);
        check({nm, "_count"}, pix_count_out, cnt);
        check({nm, "_found"}, found_out, fnd);
    endtask

    initial begin
        cyc();
        chk_en = 1'b1;
        cyc();
        cyc();
        check("rst_busy", busy_out, 0);
        check("rst_valid", res_valid_out, 0);
        check("rst_drop", drop_count_out, 0);
        check_result("rst", 0, 0, 0, 0);
        rst_n_in = 1'b1;
        cyc();

        // 1: 100 red pixels at (40,30) among non-matching ones
        start_frame(3'b001);
        for (int i = 0; i < 100; i++) begin
            pixel(3'b001, 40, 30);
            if (i % 3 == 0) pixel(3'b111, i, i);
        end
        end_frame(1'b0, 3'b111, 0, 0);
        wait_result("t1_latency", 53);
        check_result("t1", 40, 30, 100, 1);
        cyc();
        check("t1_idle_after", busy_out, 0);
        repeat (3) cyc();

        // 2: too few yellow pixels
        start_frame(3'b010);
        for (int i = 0; i < 10; i++) begin
            pixel(3'b010, 5, 5);
            pixel(3'b001, 9, 9);
            pixel(3'b001, 9, 9);
        end
        end_frame(1'b0, 3'b111, 0, 0);
        wait_result("t2_latency", 1);
        check_result("t2", 0, 0, 10, 0);
        cyc();

        // 2b: target "none" never matches
        start_frame(3'b111);
        for (int i = 0; i < 80; i++) pixel(3'b111, 3, 4);
        end_frame(1'b0, 3'b111, 0, 0);
        wait_result("t2b_latency", 1);
        check_result("t2b", 0, 0, 0, 0);
        cyc();

        // 3: 64 pixels along row 7
        start_frame(3'b001);
        for (int i = 0; i < 64; i++) pixel(3'b001, i, 7);
        end_frame(1'b0, 3'b111, 0, 0);
        wait_result("t3_latency", 53);
        check_result("t3", 31, 7, 64, 1);
        cyc();

        // frame_end while idle is ignored
        end_frame(1'b1, 3'b001, 1, 1);
        check("idle_fe_busy", busy_out, 0);

        // 4: consumer stalls, two frames dropped
        res_ready_in = 1'b0;
        start_frame(3'b001);
        for (int i = 0; i < 70; i++) pixel(3'b001, 100, 50);
        end_frame(1'b0, 3'b111, 0, 0);
        wait_result("t4_latency", 53);
        for (int i = 0; i < 200; i++) begin
            if (i == 50 || i == 120) start_frame(3'b001);
            else if (i > 50 && i < 60) pixel(3'b001, 0, 0);
            else cyc();
        end
        check("t4_still_valid", res_valid_out, 1);
        check_result("t4", 100, 50, 70, 1);
        check("t4_drop", drop_count_out, 2);
        res_ready_in = 1'b1;
        cyc();
        check("t4_valid_after", res_valid_out, 0);
        check("t4_busy_after", busy_out, 0);
        cyc();

        // 5: restart mid-frame, and a matching pixel on the frame_end cycle
        start_frame(3'b001);
        for (int i = 0; i < 5; i++) pixel(3'b001, 10, 10);
        start_frame(3'b001);
        for (int i = 0; i < 63; i++) pixel(3'b001, 20, 20);
        end_frame(1'b1, 3'b001, 20, 20);
        wait_result("t5_latency", 53);
        check_result("t5", 20, 20, 64, 1);
        cyc();

        // 6: reset during the y division
        start_frame(3'b001);
        for (int i = 0; i < 64; i++) pixel(3'b001, 8, 9);
        end_frame(1'b0, 3'b111, 0, 0);
        repeat (40) cyc();
        check("t6_busy_before", busy_out, 1);
        rst_n_in = 1'b0;
        cyc();
        rst_n_in = 1'b1;
        check("t6_busy", busy_out, 0);
        check("t6_valid", res_valid_out, 0);
        check("t6_drop", drop_count_out, 0);
        cyc();
        start_frame(3'b001);
        for (int i = 0; i < 64; i++) pixel(3'b001, 300, 200);
        end_frame(1'b0, 3'b111, 0, 0);
        wait_result("t6_latency", 53);
        check_result("t6", 300, 200, 64, 1);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
